// File: rtl/dma_copy_if.sv
// 8-bit memory bus between the DMA initiator and a decoded responder.
// Handshake: the initiator raises exactly one of read/write and holds address
// (and data_out for writes) stable until it samples ready=1 on a rising edge.
// The transfer completes on that edge. Read data is taken from data_in on the
// same edge. Afterwards the initiator keeps both strobes low until it samples
// ready=0. Only then may the next strobe begin, so a responder may hold ready
// high for any number of cycles after the strobe drops.
`timescale 1ns/1ps
interface dma_copy_if;
  logic       read;
  logic       write;
  logic       ready;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output read, write, address, data_out,
    input  ready, data_in
  );

  modport slave (
    input  read, write, address, data_out,
    output ready, data_in
  );
endinterface

// File: rtl/dma_copy.sv
// Byte-wise memory-to-memory copy engine. It reads one byte from src+i and
// writes it to dst+i. Every strobe waits for ready, with a timeout. Each
// strobe is followed by a gap state that waits for the responder to release
// ready.
`timescale 1ns/1ps
module dma_copy #(
  parameter int unsigned timeout = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg,
  dma_copy_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_GAP = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  // Value of the wait counter on the last cycle a strobe may wait without ready.
  localparam logic [7:0] TMO_LAST = 8'(timeout - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] src_r;
  logic [7:0] dst_r;
  logic [7:0] len_r;
  logic [7:0] idx;
  logic [7:0] idx_inc;
  logic [7:0] buf_r;
  logic [7:0] wcnt;
  logic       error_r;

  assign idx_inc   = idx + 8'd1;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode, including the strobe timeouts.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = (len != 8'd0) ? S_RD_REQ : S_FINISH;
      S_RD_REQ: begin
        if (bus.ready)             state_n = S_RD_GAP;
        else if (wcnt == TMO_LAST) state_n = S_FINISH;
      end
      S_RD_GAP: if (!bus.ready) state_n = S_WR_REQ;
      S_WR_REQ: begin
        if (bus.ready)             state_n = S_WR_GAP;
        else if (wcnt == TMO_LAST) state_n = S_FINISH;
      end
      S_WR_GAP: if (!bus.ready) state_n = (idx_inc == len_r) ? S_FINISH : S_RD_REQ;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Latched parameters, byte buffer, byte index, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r   <= 8'h00;
      dst_r   <= 8'h00;
      len_r   <= 8'h00;
      idx     <= 8'h00;
      buf_r   <= 8'h00;
      wcnt    <= 8'h00;
      error_r <= 1'b0;
    end else begin
      // The counter is idle at zero outside the strobe states, so each strobe
      // starts its wait from zero.
      wcnt <= 8'h00;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_r   <= src;
            dst_r   <= dst;
            len_r   <= len;
            idx     <= 8'h00;
            error_r <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (bus.ready)             buf_r   <= bus.data_in;
          else if (wcnt == TMO_LAST) error_r <= 1'b1;
          else                       wcnt    <= wcnt + 8'd1;
        end
        S_WR_REQ: begin
          if (!bus.ready && wcnt == TMO_LAST) error_r <= 1'b1;
          else if (!bus.ready)                wcnt    <= wcnt + 8'd1;
        end
        S_WR_GAP: if (!bus.ready) idx <= idx_inc;
        default: ;
      endcase
    end
  end

  // Moore outputs. Address and data are forced to zero while their strobe is low.
  always_comb begin
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.address  = 8'h00;
    bus.data_out = 8'h00;
    busy         = (state != S_IDLE);
    done         = (state == S_FINISH);
    error        = error_r;
    case (state)
      S_RD_REQ: begin
        bus.read    = 1'b1;
        bus.address = src_r + idx;
      end
      S_WR_REQ: begin
        bus.write    = 1'b1;
        bus.address  = dst_r + idx;
        bus.data_out = buf_r;
      end
      default: ;
    endcase
  end

endmodule
